// File: rtl/key_load_pkg.sv
// key_load_pkg: shared types and constants for the key-load sequencer.
// Holds the sequencer state encoding, default parameter values and the
// helper that maps the key width to the key-store address of the parity bit.
package key_load_pkg;

    localparam int KEY_W_DEF     = 8;
    localparam int TIMEOUT_DEF   = 16;
    localparam int MAX_RETRY_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHECK,
        ST_RETRY,
        ST_RELEASE,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Key bits live at addresses 0..key_w-1; the parity bit sits right after them.
    function automatic int unsigned parity_addr(input int unsigned key_w);
        return key_w;
    endfunction

endpackage

// File: rtl/key_load_timer.sv
// key_load_timer: clearable saturating cycle counter used as the mem_ack timeout.
// Latency: expire_o is combinational, high in the cycle whose increment makes the count reach TIMEOUT.
// Backpressure: none; clr_i has priority over counting and masks expire_o.
// Ports: clk, rst (async active-low), clr_i (clear), en_i (count enable), expire_o (expiry flag).
module key_load_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int             TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_MAX = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != T_MAX)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A cleared cycle (ack seen or request low) can never expire, so an ack
    // arriving in the last cycle before TIMEOUT still wins.
    assign expire_o = en_i && !clr_i && (cnt_d == T_MAX);

endmodule

// File: rtl/key_load_seq.sv
// key_load_seq: fetches a KEY_W-bit key plus even-parity bit from a serial key store, then releases the locked core.
// Latency: 1 + sum(read latencies) + KEY_W gap cycles + CHECK + RELEASE to key_valid; core_rst falls one cycle later.
// Backpressure: req/ack; mem_req/mem_addr held until mem_ack, one idle cycle between reads, TIMEOUT cycles per read.
// Ports: clk, rst (async active-low); key store mem_req/mem_addr/mem_ack/mem_data;
//        core side key_q/key_valid/core_rst; status load_fail/retry_cnt.
// Optional: define KEY_LOAD_SEQ_RELOCK_EN to add the relock input (reload from DONE).
module key_load_seq
    import key_load_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef KEY_LOAD_SEQ_RELOCK_EN
    input  logic                             relock,
`endif
    output logic                             mem_req,
    output logic [$clog2(KEY_W+1)-1:0]       mem_addr,
    input  logic                             mem_ack,
    input  logic                             mem_data,
    output logic [KEY_W-1:0]                 key_q,
    output logic                             key_valid,
    output logic                             core_rst,
    output logic                             load_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    localparam int            AW        = $clog2(KEY_W + 1);
    localparam int            RW        = $clog2(MAX_RETRY + 1);
    localparam logic [AW-1:0] PAR_ADDR  = AW'(parity_addr(KEY_W));
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t            state_q;
    logic              mem_req_q;
    logic [AW-1:0]     idx_q;
    logic [KEY_W-1:0]  shadow_q;
    logic              par_q;
    logic [KEY_W-1:0]  key_out_q;
    logic              key_valid_q;
    logic              core_rst_q;
    logic              load_fail_q;
    logic [RW-1:0]     retry_q;
    logic [RW-1:0]     retry_d;

    logic              tmr_clr;
    logic              tmr_expire;

    // The timer only runs while a request is outstanding; an accepted ack
    // or the idle gap between reads restarts it from zero.
    assign tmr_clr = !mem_req_q || mem_ack;

    key_load_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .en_i     (mem_req_q),
        .expire_o (tmr_expire)
    );

    assign retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            idx_q       <= '0;
            shadow_q    <= '0;
            par_q       <= 1'b0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            core_rst_q  <= 1'b1;
            load_fail_q <= 1'b0;
            retry_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_q     <= '0;
                    shadow_q  <= '0;
                    mem_req_q <= 1'b1;
                    state_q   <= ST_REQ;
                end
                ST_REQ: begin
                    if (!mem_req_q) begin
                        // Single idle cycle after an accepted read; any ack here is ignored.
                        mem_req_q <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (idx_q == PAR_ADDR) begin
                            par_q   <= mem_data;
                            state_q <= ST_CHECK;
                        end else begin
                            for (int i = 0; i < KEY_W; i++) begin
                                if (idx_q == AW'(i)) begin
                                    shadow_q[i] <= mem_data;
                                end
                            end
                            idx_q <= idx_q + AW'(1);
                        end
                    end else if (tmr_expire) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_RETRY;
                    end
                end
                ST_CHECK: begin
                    // Even parity: stored bit equals XOR of the key bits.
                    if ((^shadow_q) == par_q) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    retry_q <= retry_d;
                    if (retry_d == RETRY_MAX) begin
                        load_fail_q <= 1'b1;
                        state_q     <= ST_FAIL;
                    end else begin
                        shadow_q  <= '0;
                        idx_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_RELEASE: begin
                    // Key becomes visible a full cycle before core_rst drops.
                    key_out_q   <= shadow_q;
                    key_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
`ifdef KEY_LOAD_SEQ_RELOCK_EN
                    if (relock) begin
                        core_rst_q  <= 1'b1;
                        key_valid_q <= 1'b0;
                        key_out_q   <= '0;
                        retry_q     <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        core_rst_q <= 1'b0;
                    end
`else
                    core_rst_q <= 1'b0;
`endif
                end
                ST_FAIL: begin
                    load_fail_q <= 1'b1;
                    core_rst_q  <= 1'b1;
                    key_out_q   <= '0;
                    key_valid_q <= 1'b0;
                    mem_req_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = idx_q;
    assign key_q     = key_out_q;
    assign key_valid = key_valid_q;
    assign core_rst  = core_rst_q;
    assign load_fail = load_fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_key_load_seq.sv
// tb_key_load_seq: directed vector table, corner sequences and randomized loads
// for key_load_seq, checked against a request-level reference model.
module tb_key_load_seq;

    localparam int KW = 8;
    localparam int TO = 16;
    localparam int MR = 3;

    logic            clk;
    logic            rst;
    logic            mem_req;
    logic [3:0]      mem_addr;
    logic            mem_ack;
    logic            mem_data;
    logic [KW-1:0]   key_q;
    logic            key_valid;
    logic            core_rst;
    logic            load_fail;
    logic [1:0]      retry_cnt;
`ifdef KEY_LOAD_SEQ_RELOCK_EN
    logic            relock;
`endif

    key_load_seq #(.KEY_W(KW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef KEY_LOAD_SEQ_RELOCK_EN
        .relock    (relock),
`endif
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .key_q     (key_q),
        .key_valid (key_valid),
        .core_rst  (core_rst),
        .load_fail (load_fail),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per key-store request, in the order the store sees them.
    typedef struct {
        int   dly;   // cycles mem_req is high before ack; >= TO means no ack in time
        logic dat;
    } req_t;

    typedef struct {
        int          dly0;
        int          dly;
        logic [7:0]  key_a;
        logic        par_a;
        logic [7:0]  key_b;
        logic        par_b;
        logic [7:0]  exp_key;
        int          exp_retry;
        logic        exp_fail;
        int          exp_cyc;
    } vec_t;

    req_t stim_q[$];
    req_t resp_q[$];
    int   addr_log[$];
    int   exp_addr[$];

    int          exp_cyc;
    int          exp_retry;
    logic        exp_fail;
    logic [7:0]  exp_key;

    int n_chk  = 0;
    int n_fail = 0;
    int inv_err = 0;
    bit noise  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Key-store responder: acks each request after its programmed delay.
    initial begin
        req_t cur;
        bit   active;
        int   wcnt;
        active   = 0;
        wcnt     = 0;
        cur      = '{dly: 999, dat: 1'b0};
        mem_ack  = 1'b0;
        mem_data = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!active) begin
                    if (resp_q.size() > 0) cur = resp_q.pop_front();
                    else cur = '{dly: 999, dat: 1'b0};
                    addr_log.push_back(int'(mem_addr));
                    active = 1;
                    wcnt   = 0;
                end
                mem_ack  = (wcnt == cur.dly);
                mem_data = mem_ack ? cur.dat : 1'($urandom);
                wcnt++;
            end else begin
                active   = 0;
                mem_ack  = noise ? 1'($urandom) : 1'b0;
                mem_data = 1'($urandom);
            end
        end
    end

    // Continuous properties: key frozen while the core runs, zero unless valid.
    logic [KW-1:0] prev_key = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!core_rst && (key_q != prev_key)) inv_err++;
                if (!key_valid && (key_q != '0)) inv_err++;
            end
            prev_key = key_q;
        end
    end

    // Reference model: walks the request list and predicts the outcome.
    task automatic model_run();
        int          p;
        int          idx;
        logic [7:0]  sh;
        req_t        r;
        bit          fin;
        bit          bad;
        p = 0; idx = 0; sh = '0; fin = 0;
        exp_cyc = 1; exp_retry = 0; exp_fail = 1'b0; exp_key = '0;
        exp_addr.delete();
        while (!fin) begin
            if (p < stim_q.size()) r = stim_q[p];
            else r = '{dly: 999, dat: 1'b0};
            p++;
            exp_addr.push_back(idx);
            bad = 0;
            if (r.dly >= TO) begin
                exp_cyc += TO + 1;
                bad = 1;
            end else begin
                exp_cyc += r.dly + 1;
                if (idx < KW) begin
                    sh[idx] = r.dat;
                    idx++;
                    exp_cyc += 1;
                end else if (($countones(sh) % 2) == int'(r.dat)) begin
                    exp_cyc += 2;
                    exp_key = sh;
                    fin = 1;
                end else begin
                    exp_cyc += 2;
                    bad = 1;
                end
            end
            if (bad) begin
                exp_retry++;
                if (exp_retry == MR) begin
                    exp_fail = 1'b1;
                    fin = 1;
                end else begin
                    idx = 0;
                    sh  = '0;
                end
            end
        end
    endtask

    task automatic push_attempt(input logic [7:0] k, input logic par, input int d0, input int d);
        for (int i = 0; i <= KW; i++) begin
            int dd;
            dd = (i == 0) ? d0 : d;
            stim_q.push_back('{dly: dd, dat: (i < KW) ? k[i] : par});
            if (dd >= TO) break;
        end
    endtask

    task automatic gen_random();
        stim_q.delete();
        for (int a = 0; a < MR; a++) begin
            logic [7:0] k;
            logic       par;
            k   = 8'($urandom);
            par = ^k;
            if ($urandom_range(0, 4) == 0) par = ~par;
            for (int i = 0; i <= KW; i++) begin
                int d;
                int r;
                r = $urandom_range(0, 19);
                if (r < 14)      d = $urandom_range(0, 3);
                else if (r < 18) d = $urandom_range(4, 15);
                else             d = $urandom_range(16, 18);
                stim_q.push_back('{dly: d, dat: (i < KW) ? k[i] : par});
                if (d >= TO) break;
            end
        end
    endtask

    // Reset the DUT, arm the responder and release reset on a falling edge.
    task automatic start_load();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_q = stim_q;
        addr_log.delete();
        rst = 1'b1;
    endtask

    // Count rising edges until key_valid or load_fail and compare with exp_*.
    task automatic run_load(input string nm);
        int n;
        bit hit;
        int mism;
        n = 0; hit = 0; mism = 0;
        while (!hit && n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            hit = key_valid || load_fail;
        end
        chk({nm, " finished"}, 32'(hit), 32'd1);
        chk({nm, " cycles"}, 32'(n), 32'(exp_cyc));
        chk({nm, " key_valid"}, 32'(key_valid), 32'(!exp_fail));
        chk({nm, " load_fail"}, 32'(load_fail), 32'(exp_fail));
        chk({nm, " key_q"}, 32'(key_q), 32'(exp_key));
        chk({nm, " retry_cnt"}, 32'(retry_cnt), 32'(exp_retry));
        chk({nm, " core_rst_held"}, 32'(core_rst), 32'd1);
        chk({nm, " addr_count"}, 32'(addr_log.size()), 32'(exp_addr.size()));
        foreach (exp_addr[i]) begin
            if (i >= addr_log.size() || addr_log[i] != exp_addr[i]) mism++;
        end
        chk({nm, " addr_mismatches"}, 32'(mism), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " core_rst_next"}, 32'(core_rst), 32'(exp_fail));
        chk({nm, " mem_req_idle"}, 32'(mem_req), 32'd0);
        chk({nm, " key_q_hold"}, 32'(key_q), 32'(exp_key));
    endtask

    vec_t vecs[7];

    initial begin
        rst = 1'b0;
`ifdef KEY_LOAD_SEQ_RELOCK_EN
        relock = 1'b0;
`endif
        vecs[0] = '{dly0: 2,  dly: 2,  key_a: 8'hA5, par_a: 1'b0, key_b: 8'hA5, par_b: 1'b0,
                    exp_key: 8'hA5, exp_retry: 0, exp_fail: 1'b0, exp_cyc: 38};
        vecs[1] = '{dly0: 2,  dly: 2,  key_a: 8'h01, par_a: 1'b0, key_b: 8'h01, par_b: 1'b1,
                    exp_key: 8'h01, exp_retry: 1, exp_fail: 1'b0, exp_cyc: 75};
        vecs[2] = '{dly0: 99, dly: 99, key_a: 8'h00, par_a: 1'b0, key_b: 8'h00, par_b: 1'b0,
                    exp_key: 8'h00, exp_retry: 3, exp_fail: 1'b1, exp_cyc: 52};
        vecs[3] = '{dly0: 15, dly: 0,  key_a: 8'hC3, par_a: 1'b0, key_b: 8'hC3, par_b: 1'b0,
                    exp_key: 8'hC3, exp_retry: 0, exp_fail: 1'b0, exp_cyc: 35};
        vecs[4] = '{dly0: 16, dly: 0,  key_a: 8'hA5, par_a: 1'b0, key_b: 8'h5A, par_b: 1'b0,
                    exp_key: 8'h5A, exp_retry: 1, exp_fail: 1'b0, exp_cyc: 37};
        vecs[5] = '{dly0: 0,  dly: 0,  key_a: 8'hFF, par_a: 1'b1, key_b: 8'hFF, par_b: 1'b1,
                    exp_key: 8'h00, exp_retry: 3, exp_fail: 1'b1, exp_cyc: 58};
        vecs[6] = '{dly0: 1,  dly: 1,  key_a: 8'h80, par_a: 1'b1, key_b: 8'h80, par_b: 1'b1,
                    exp_key: 8'h80, exp_retry: 0, exp_fail: 1'b0, exp_cyc: 29};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset key_q", 32'(key_q), 32'd0);
        chk("reset key_valid", 32'(key_valid), 32'd0);
        chk("reset core_rst", 32'(core_rst), 32'd1);
        chk("reset load_fail", 32'(load_fail), 32'd0);
        chk("reset retry_cnt", 32'(retry_cnt), 32'd0);

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            stim_q.delete();
            push_attempt(vecs[v].key_a, vecs[v].par_a, vecs[v].dly0, vecs[v].dly);
            push_attempt(vecs[v].key_b, vecs[v].par_b, vecs[v].dly, vecs[v].dly);
            push_attempt(vecs[v].key_b, vecs[v].par_b, vecs[v].dly, vecs[v].dly);
            model_run();
            exp_cyc   = vecs[v].exp_cyc;
            exp_key   = vecs[v].exp_key;
            exp_retry = vecs[v].exp_retry;
            exp_fail  = vecs[v].exp_fail;
            start_load();
            run_load($sformatf("vec%0d", v));
        end

        // Asynchronous reset in the middle of a load (address 4 outstanding).
        begin
            int n;
            bit found;
            stim_q.delete();
            push_attempt(8'hA5, 1'b0, 1, 1);
            start_load();
            n = 0; found = 0;
            while (!found && n < 500) begin
                @(negedge clk);
                n++;
                found = mem_req && (mem_addr == 4'd4);
            end
            chk("midrst reached_idx4", 32'(found), 32'd1);
            #2 rst = 1'b0;
            #1;
            chk("midrst mem_req", 32'(mem_req), 32'd0);
            chk("midrst mem_addr", 32'(mem_addr), 32'd0);
            chk("midrst key_valid", 32'(key_valid), 32'd0);
            chk("midrst core_rst", 32'(core_rst), 32'd1);
            chk("midrst retry_cnt", 32'(retry_cnt), 32'd0);
            stim_q.delete();
            push_attempt(8'h96, 1'b0, 1, 1);
            model_run();
            start_load();
            run_load("midrst reload");
        end

        // Randomized loads with ack noise while mem_req is low.
        noise = 1;
        for (int it = 0; it < 30; it++) begin
            gen_random();
            model_run();
            start_load();
            run_load($sformatf("rnd%0d", it));
        end
        noise = 0;

`ifdef KEY_LOAD_SEQ_RELOCK_EN
        // Relock from DONE and reload a new key.
        stim_q.delete();
        push_attempt(8'hA5, 1'b0, 2, 2);
        model_run();
        start_load();
        run_load("relock first");
        stim_q.delete();
        push_attempt(8'h3C, 1'b0, 1, 1);
        model_run();
        resp_q = stim_q;
        addr_log.delete();
        relock = 1'b1;
        @(posedge clk);
        @(negedge clk);
        relock = 1'b0;
        chk("relock core_rst", 32'(core_rst), 32'd1);
        chk("relock key_valid", 32'(key_valid), 32'd0);
        chk("relock key_q", 32'(key_q), 32'd0);
        chk("relock retry_cnt", 32'(retry_cnt), 32'd0);
        run_load("relock reload");
`endif

        chk("invariant violations", 32'(inv_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_load_seq.md
Name: key_load_seq

Overview:
- Sequencer that provisions the locking key for a locked benchmark FSM core.
- Holds the core in reset, fetches KEY_W key bits plus one even-parity bit from a serial key store over a req/ack handshake, and checks parity.
- On a good check, drives the key onto the core's keyinput bus and releases the core's active-high reset.
- Sits between the on-chip key store and the core's keyinput*/rst pins.

Parameters:
- KEY_W, 8, number of key bits, one key-store read each (1..32).
- TIMEOUT, 16, cycles to wait for mem_ack before the attempt fails (>=2).
- MAX_RETRY, 3, failed attempts tolerated before entering FAIL (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_req  out  1  key-store read request.
- mem_addr  out  $clog2(KEY_W+1)  read address; 0..KEY_W-1 are key bits, KEY_W is the parity bit.
- mem_ack  in  1  read acknowledge; mem_data is valid in the same cycle.
- mem_data  in  1  read data bit.
- key_q  out  KEY_W  key to core keyinputs; zero unless key_valid.
- key_valid  out  1  key loaded and checked.
- core_rst  out  1  active-high reset to the locked core.
- load_fail  out  1  sticky; retries exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts so far.

Behaviour:
- Reset (rst=0, async) forces:
  - State IDLE.
  - mem_req=0, mem_addr=0, key_q=0, key_valid=0, core_rst=1, load_fail=0, retry_cnt=0.
  - Shadow register, index and timer cleared.
- The same values apply if rst asserts mid-load or after DONE.
- States and transitions:
  - IDLE: on the next clk after rst release, idx=0, go to REQ.
  - REQ:
    - Drive mem_req=1 and mem_addr=idx. Both stay stable until ack.
    - The timer counts cycles with mem_req=1.
    - On a cycle with mem_ack=1:
      - If idx<KEY_W, write mem_data into shadow[idx] and increment idx.
      - If idx==KEY_W, capture mem_data as the parity bit and go to CHECK.
      - mem_req drops for exactly one cycle between reads; the timer clears.
    - If the timer reaches TIMEOUT with no ack, go to RETRY.
    - mem_ack while mem_req=0 is ignored.
  - CHECK (1 cycle): if XOR(shadow) == parity bit, go to RELEASE; otherwise go to RETRY.
  - RETRY (1 cycle):
    - Increment retry_cnt.
    - If retry_cnt+1 == MAX_RETRY, go to FAIL.
    - Otherwise clear shadow, set idx=0 and go to REQ.
  - RELEASE (1 cycle): key_q <= shadow, key_valid <= 1. core_rst stays 1.
  - DONE: core_rst=0; remain here until reset.
  - FAIL: load_fail=1, core_rst=1, key_q=0, mem_req=0; remain here until reset.
- Latency:
  - A clean load takes 1 (IDLE) + sum of the KEY_W+1 read latencies + KEY_W one-cycle gaps + CHECK + RELEASE.
  - core_rst falls exactly one cycle after key_valid rises.
  - The key is always stable before the core leaves reset.
- Boundary conditions:
  - An ack on the last cycle before TIMEOUT is accepted. The timeout fires only when the count equals TIMEOUT with ack=0.
  - retry_cnt saturates at MAX_RETRY.
  - key_q never changes while core_rst=0.

Optional Feature:
- Macro: KEY_LOAD_SEQ_RELOCK_EN.
- When defined:
  - Adds input relock (1 bit).
  - relock=1 sampled in DONE forces next-cycle core_rst=1, key_valid=0 and key_q=0, then moves to IDLE and reloads. retry_cnt is cleared.
  - relock in any other state is ignored.
- When undefined: there is no relock port and DONE is terminal until reset.

Decomposition:
- Shared package key_load_pkg holds:
  - State enum (IDLE, REQ, CHECK, RETRY, RELEASE, DONE, FAIL).
  - Parity-bit address function.
  - Default parameter constants.
- One sub-module, key_load_timer: a clearable saturating counter with an expiry flag at TIMEOUT, used for the ack timeout.

Test Plan:
1. KEY_W=8; store holds key 8'hA5 (parity 0); ack after 2 cycles on every read -> key_q=8'hA5 and key_valid=1; core_rst falls one cycle later; retry_cnt=0, load_fail=0.
2. Key 8'h01 with stored parity 0 (wrong) on the first attempt, correct on the second -> retry_cnt=1, then key_q=8'h01 and DONE.
3. mem_ack never asserted -> 3 timeouts of 16 cycles each, retry_cnt=3, load_fail=1, core_rst=1, key_q=0, mem_req=0.
4. Ack at exactly cycle 15 of waiting -> bit accepted, no retry; ack first arrives at cycle 16 -> timeout, then RETRY.
5. rst pulsed low mid-load while idx=4 -> all outputs return to reset values asynchronously; the load restarts from addr 0 after release.
6. (RELOCK_EN) relock=1 in DONE -> next cycle core_rst=1, key_valid=0; full reload of new key 8'h3C completes and releases the core.
